// File: rtl/mips_pkg.sv
// Shared definitions for the execute stage.
// Holds the ALU operation codes, the forward-select encodings, the mul/div
// FSM state type and two small helpers: an operand-forwarding mux and a
// decoder for the mul/div operation class.
package mips_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {IDLE, BUSY} md_state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Select 2'b11 falls back to the register file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_start         accept i_op/i_a/i_b (only honoured while idle)
//   i_op            MULT/MULTU/DIV/DIVU code
//   i_a, i_b        operands (A = multiplier/dividend, B = multiplicand/divisor)
//   o_busy          high while an operation is in flight (FSM state == BUSY)
//   o_hi, o_lo      HI/LO registers
// Operands are reduced to magnitudes on accept; one shift-add or restoring
// subtract step runs per cycle and the sign fix-up is applied on the final
// step, which writes HI/LO on the MD_ITER-th edge after accept.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [5:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CW = $clog2(MD_ITER);

  md_state_t r_state, w_state_nx;
  logic          w_last;
  logic [CW-1:0] r_cnt;
  logic          r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [31:0]   r_b, r_acc, r_q, r_hi, r_lo;

  logic        w_signed;
  logic [32:0] w_mul_sum, w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_sub, w_acc_nx, w_q_nx, w_quot, w_rem, w_hi_fix, w_lo_fix;
  logic [63:0] w_prod, w_prod_fix;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_last     = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nx = BUSY;
      BUSY: if (r_cnt == CW'(MD_ITER - 1)) begin
        w_state_nx = IDLE;
        w_last     = 1'b1;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);

  // Multiply: {r_acc, r_q} is the shifting product, r_q starts as multiplier.
  assign w_mul_sum = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_b}) : {1'b0, r_acc};
  // Divide: r_acc is the partial remainder, r_q shifts the dividend out and
  // the quotient in. The difference always fits 32 bits when taken.
  assign w_div_sh  = {r_acc, r_q[31]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_b};
  assign w_div_sub = w_div_sh[31:0] - r_b;

  assign w_acc_nx = r_is_div ? (w_div_ge ? w_div_sub : w_div_sh[31:0]) : w_mul_sum[32:1];
  assign w_q_nx   = r_is_div ? {r_q[30:0], w_div_ge} : {w_mul_sum[0], r_q[31:1]};

  assign w_prod     = {w_acc_nx, w_q_nx};
  assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
  // Divide by zero leaves |A| in the remainder, so the normal remainder
  // sign fix-up restores A exactly; only the quotient needs forcing.
  assign w_quot   = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_q_nx) : w_q_nx);
  assign w_rem    = r_neg_r ? (32'd0 - w_acc_nx) : w_acc_nx;
  assign w_hi_fix = r_is_div ? w_rem  : w_prod_fix[63:32];
  assign w_lo_fix = r_is_div ? w_quot : w_prod_fix[31:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == IDLE) begin
      if (i_start) begin
        r_is_div <= (i_op == OP_DIV) || (i_op == OP_DIVU);
        r_neg_q  <= w_signed && (i_a[31] ^ i_b[31]);
        r_neg_r  <= w_signed && i_a[31];
        r_dz     <= (i_b == 32'd0);
        r_q      <= (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
        r_b      <= (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
    end else begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign o_busy = (r_state == BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, destination select,
// and the stall generated by the iterative mul/div unit.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   valid_ex_i, alu_op_ex_i        instruction valid and operation code
//   alu_src_ex_i, reg_dst_ex_i     operand B / destination selects
//   rt_ex_i, rd_ex_i               register indices
//   r_data_p1/p2_ex_i, sign_imm    regfile values and immediate (shamt [10:6])
//   fwd_a/b_ex_i                   forward selects (RF/WB/MEM)
//   alu_out_mem_i, result_wb_i     forwarding sources
//   alu_out_ex_o, wr_data_ex_o     result and store data
//   wr_reg_ex_o, stall_ex_o        destination index and upstream stall
//   hi_o, lo_o                     HI/LO registers
// Stall semantics: stall_ex_o=1 means this cycle's instruction is not
// consumed; upstream must hold it unchanged until stall_ex_o drops.
module ex_stage
  import mips_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MD_ITER = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_ex_i,
  input  logic [5:0]    alu_op_ex_i,
  input  logic          alu_src_ex_i,
  input  logic          reg_dst_ex_i,
  input  logic [4:0]    rt_ex_i,
  input  logic [4:0]    rd_ex_i,
  input  logic [DW-1:0] r_data_p1_ex_i,
  input  logic [DW-1:0] r_data_p2_ex_i,
  input  logic [DW-1:0] sign_imm_ex_i,
  input  logic [1:0]    fwd_a_ex_i,
  input  logic [1:0]    fwd_b_ex_i,
  input  logic [DW-1:0] alu_out_mem_i,
  input  logic [DW-1:0] result_wb_i,
  output logic [DW-1:0] alu_out_ex_o,
  output logic [DW-1:0] wr_data_ex_o,
  output logic [4:0]    wr_reg_ex_o,
  output logic          stall_ex_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW-1:0] w_a, w_fwd_b, w_b, w_hi, w_lo, w_alu;
  logic [4:0]    w_shamt;
  logic          w_md_op, w_busy, w_start;

  assign w_a     = fwd_mux(fwd_a_ex_i, r_data_p1_ex_i, result_wb_i, alu_out_mem_i);
  assign w_fwd_b = fwd_mux(fwd_b_ex_i, r_data_p2_ex_i, result_wb_i, alu_out_mem_i);
  assign w_b     = alu_src_ex_i ? sign_imm_ex_i : w_fwd_b;
  assign w_shamt = sign_imm_ex_i[10:6];

  always_comb begin
    w_alu = '0;
    case (alu_op_ex_i)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_NOR:  w_alu = ~(w_a | w_b);
      OP_SLT:  w_alu = ($signed(w_a) < $signed(w_b)) ? 32'd1 : 32'd0;
      OP_SLTU: w_alu = (w_a < w_b) ? 32'd1 : 32'd0;
      OP_SLL:  w_alu = w_b << w_shamt;
      OP_SRL:  w_alu = w_b >> w_shamt;
      OP_SRA:  w_alu = $signed(w_b) >>> w_shamt;
      OP_LUI:  w_alu = w_b << 16;
      OP_MFHI: w_alu = w_hi;
      OP_MFLO: w_alu = w_lo;
      default: w_alu = '0;
    endcase
  end

  assign w_md_op = is_muldiv(alu_op_ex_i);
  assign w_start = valid_ex_i && w_md_op && !w_busy;

  muldiv_unit #(.MD_ITER(MD_ITER)) u_muldiv (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (w_start),
    .i_op    (alu_op_ex_i),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign stall_ex_o   = w_busy && valid_ex_i &&
                        (w_md_op || (alu_op_ex_i == OP_MFHI) || (alu_op_ex_i == OP_MFLO));
  assign alu_out_ex_o = w_alu;
  assign wr_data_ex_o = w_fwd_b;
  assign wr_reg_ex_o  = reg_dst_ex_i ? rd_ex_i : rt_ex_i;
  assign hi_o         = w_hi;
  assign lo_o         = w_lo;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid, alu_src, reg_dst;
  logic [5:0]  op;
  logic [4:0]  rt, rd;
  logic [31:0] p1, p2, imm, mem_v, wb_v;
  logic [1:0]  fa, fb;
  logic [31:0] alu_out, wr_data, hi, lo;
  logic [4:0]  wr_reg;
  logic        stall;

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_ex_i(valid), .alu_op_ex_i(op),
    .alu_src_ex_i(alu_src), .reg_dst_ex_i(reg_dst), .rt_ex_i(rt), .rd_ex_i(rd),
    .r_data_p1_ex_i(p1), .r_data_p2_ex_i(p2), .sign_imm_ex_i(imm),
    .fwd_a_ex_i(fa), .fwd_b_ex_i(fb), .alu_out_mem_i(mem_v), .result_wb_i(wb_v),
    .alu_out_ex_o(alu_out), .wr_data_ex_o(wr_data), .wr_reg_ex_o(wr_reg),
    .stall_ex_o(stall), .hi_o(hi), .lo_o(lo)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;       // architectural HI/LO as the model sees them
  logic [31:0] exp_q[$];         // pending {HI, LO} of the in-flight mul/div
  int          m_rem;            // cycles until the pending result lands
  logic        last_stall;
  logic [31:0] last_alu;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'b01) return wb_v;
    if (s == 2'b10) return mem_v;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_ADD:  return 32'(longint'(a) + longint'(b));
      OP_SUB:  return 32'(longint'(a) - longint'(b));
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return 32'(longint'(b) * (longint'(1) << sh));
      OP_SRL:  return 32'(longint'(b) / (longint'(1) << sh));
      OP_SRA:  return 32'(sb >>> sh);
      OP_LUI:  return 32'(longint'(b) * 65536);
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      OP_MULT:  begin p = sa * sb; pv = 64'(p); rh = pv[63:32]; rl = pv[31:0]; end
      OP_MULTU: begin pv = {32'd0, a} * {32'd0, b}; rh = pv[63:32]; rl = pv[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else begin
          if (o == OP_DIVU) begin sa = longint'(a); sb = longint'(b); end
          q = sa / sb;
          r = sa % sb;
          rl = 32'(q);
          rh = 32'(r);
        end
      end
      default: ;
    endcase
  endtask

  // One clock: check combinational outputs mid-low-phase, then advance model.
  task automatic cycle();
    logic [31:0] a, fbv, b, rh, rl;
    logic        busy, exp_stall;
    #1;
    a    = fwd_ref(fa, p1);
    fbv  = fwd_ref(fb, p2);
    b    = alu_src ? imm : fbv;
    busy = (m_rem > 0);
    exp_stall = busy && valid && (is_muldiv(op) || op == OP_MFHI || op == OP_MFLO);
    check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
    check_val("wr_data", wr_data, fbv);
    check_val("wr_reg", {27'd0, wr_reg}, {27'd0, reg_dst ? rd : rt});
    check_val("hi", hi, m_hi);
    check_val("lo", lo, m_lo);
    if (!exp_stall) check_val("alu_out", alu_out, alu_ref(op, a, b, int'(imm[10:6])));
    last_stall = stall;
    last_alu   = alu_out;
    @(posedge clk);
    if (reset) begin
      m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = exp_q.pop_front();
        m_lo = exp_q.pop_front();
      end
    end else if (valid && is_muldiv(op)) begin
      md_ref(op, a, b, rh, rl);
      exp_q.push_back(rh);
      exp_q.push_back(rl);
      m_rem = 32;
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src);
    valid = 1'b1; op = o; p1 = a; p2 = b; imm = im; alu_src = src;
    fa = FWD_RF; fb = FWD_RF;
  endtask

  task automatic run_until_free(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_stall) break;
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [5:0] op_tab [0:19];
  int n;

  initial begin
    op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL,
               OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV,
               OP_DIVU, 6'h3F, OP_ADD};
    reset = 1'b1; valid = 1'b0; op = OP_ADD; alu_src = 1'b0; reg_dst = 1'b0;
    rt = 5'd3; rd = 5'd9; p1 = '0; p2 = '0; imm = '0; mem_v = '0; wb_v = '0;
    fa = FWD_RF; fb = FWD_RF;
    m_hi = '0; m_lo = '0; m_rem = 0; last_stall = 1'b0; last_alu = '0;
    @(posedge clk); @(negedge clk);
    valid = 1'b1; op = OP_MFHI;
    cycle();                               // reset state checks
    reset = 1'b0;

    // ADD with MEM forwarding on A
    drive(OP_ADD, 32'd99, 32'd7, 32'd0, 1'b0); fa = FWD_MEM; mem_v = 32'd5; reg_dst = 1'b1;
    cycle();
    check_val("add_fwd_mem", last_alu, 32'd12);
    check_val("add_nostall", {31'd0, last_stall}, 32'd0);
    reg_dst = 1'b0;

    drive(OP_SRA, 32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0); cycle();
    check_val("sra", last_alu, 32'hF800_0000);
    drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); cycle();
    check_val("sltu", last_alu, 32'd0);
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); cycle();
    check_val("slt", last_alu, 32'd1);

    // MULT then MFLO: exactly 32 stalled cycles
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0); cycle();
    drive(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
    run_until_free(n);
    check_val("mult_stall_cycles", n, 32'd32);
    check_val("mflo_after_mult", last_alu, 32'hFFFF_FFFA);
    check_val("hi_after_mult", hi, 32'hFFFF_FFFF);

    // ADD while BUSY proceeds
    drive(OP_MULTU, 32'd6, 32'd7, 32'd0, 1'b0); cycle();
    drive(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0); cycle();
    check_val("add_in_busy_nostall", {31'd0, last_stall}, 32'd0);
    check_val("add_in_busy_val", last_alu, 32'd3);
    idle_cycles(34);

    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0); cycle();
    drive(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0); run_until_free(n);
    check_val("div_lo", last_alu, 32'hFFFF_FFFD);
    check_val("div_hi", hi, 32'hFFFF_FFFF);

    drive(OP_DIVU, 32'd7, 32'd0, 32'd0, 1'b0); cycle();
    drive(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0); run_until_free(n);
    check_val("divu0_hi", last_alu, 32'd7);
    check_val("divu0_lo", lo, 32'hFFFF_FFFF);

    // MULTU then DIVU back-to-back serialize
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0); cycle();
    drive(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0); run_until_free(n);
    check_val("divu_b2b_stall", n, 32'd32);
    check_val("multu_hi", hi, 32'hFFFF_FFFE);
    drive(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0); run_until_free(n);
    check_val("divu_b2b_stall2", n, 32'd32);
    check_val("divu_b2b_lo", last_alu, 32'd14);
    check_val("divu_b2b_hi", hi, 32'd2);

    // reset during DIV iteration 10
    drive(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0); cycle();
    idle_cycles(10);
    reset = 1'b1; cycle(); reset = 1'b0;
    drive(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0); cycle();
    check_val("rst_mid_stall", {31'd0, last_stall}, 32'd0);
    check_val("rst_mid_mfhi", last_alu, 32'd0);
    check_val("rst_mid_lo", lo, 32'd0);

    // randomized traffic; stalled instructions are held as upstream would
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        valid   = ($urandom_range(0, 7) != 0);
        op      = op_tab[$urandom_range(0, 19)];
        alu_src = $urandom_range(0, 1) == 1;
        reg_dst = $urandom_range(0, 1) == 1;
        rt = 5'($urandom); rd = 5'($urandom);
        p1 = $urandom; p2 = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
        imm = $urandom; mem_v = $urandom; wb_v = $urandom;
        fa = 2'($urandom); fb = 2'($urandom);
      end
      cycle();
    end
    idle_cycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
